// File: rtl/kf_dma_priority_arbiter_if.sv
// Grant handshake between the DMA request arbiter and the DMA timing/control FSM.
// The arbiter drives the grant; the controller answers with accept/done/EOP.
interface kf_dma_priority_arbiter_if #(
    parameter int CHANNELS = 4,
    parameter int CH_W     = $clog2(CHANNELS)
);
    logic                grant_valid;
    logic [CH_W-1:0]     grant_channel;
    logic [CHANNELS-1:0] grant_onehot;
    logic                grant_accept;
    logic                service_done;
    logic                end_of_process;

    // Arbiter side
    modport master (
        output grant_valid,
        output grant_channel,
        output grant_onehot,
        input  grant_accept,
        input  service_done,
        input  end_of_process
    );

    // Controller side
    modport slave (
        input  grant_valid,
        input  grant_channel,
        input  grant_onehot,
        output grant_accept,
        output service_done,
        output end_of_process
    );
endinterface

// File: rtl/kf_dma_priority_arbiter.sv
// KF8237-family DMA request arbiter: per-channel mask, software request and
// edge lock, fixed or rotating priority, registered offer/accept/done grant.
module kf_dma_priority_arbiter #(
    parameter int CHANNELS = 4,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                master_clear,
    input  logic                write_command,
    input  logic                cmd_disable,
    input  logic                cmd_rotating,
    input  logic                cmd_active_low,
    input  logic                mask_set_all,
    input  logic                mask_single,
    input  logic [CH_W-1:0]     mask_channel,
    input  logic                mask_value,
    input  logic                mask_write_all,
    input  logic [CHANNELS-1:0] mask_bus,
    input  logic                request_write,
    input  logic [CH_W-1:0]     request_channel,
    input  logic                request_value,
    input  logic [CHANNELS-1:0] edge_sense,
    input  logic [CHANNELS-1:0] dma_request,
    kf_dma_priority_arbiter_if.master gnt
);

    localparam logic [CH_W:0]   CH_COUNT = (CH_W+1)'(CHANNELS);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CHANNELS-1:0] softreq_q, softreq_d;
    logic [CHANNELS-1:0] lock_q, lock_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic                cmd_disable_q, cmd_disable_d;
    logic                cmd_rotating_q, cmd_rotating_d;
    logic                cmd_active_low_q, cmd_active_low_d;
    logic [CH_W-1:0]     grant_channel_q, grant_channel_d;
    logic                grant_valid_q, grant_valid_d;
    logic [CHANNELS-1:0] grant_onehot_q, grant_onehot_d;

    logic [CHANNELS-1:0]   dreq_act;
    logic [CHANNELS-1:0]   act;
    logic                  act_any;
    logic                  in_busy;
    logic [CHANNELS-1:0]   lock_set;
    logic [2*CHANNELS-1:0] act_dbl;
    logic [CHANNELS-1:0]   act_rot;
    logic [CH_W-1:0]       base;
    logic [CH_W-1:0]       win_off;
    logic [CH_W:0]         win_sum;
    logic [CH_W-1:0]       winner;
    logic [CH_W-1:0]       ptr_after_grant;

    // DREQ at its programmed polarity, then the arbitration candidate set
    assign dreq_act = dma_request ^ {CHANNELS{cmd_active_low_q}};
    assign act      = (dreq_act & ~lock_q & ~mask_q) | softreq_q;
    assign act_any  = |act;
    assign in_busy  = (state_q == ST_BUSY);

    assign ptr_after_grant = (grant_channel_q == CH_LAST) ? '0 : grant_channel_q + 1'b1;

    // Per-channel edge lock and grant one-hot decode
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign lock_set[gi] = in_busy && gnt.service_done && edge_sense[gi]
                              && (grant_channel_q == CH_W'(gi));
        // A lock survives only while the channel is edge-sensed and DREQ stays active
        assign lock_d[gi] = mask_set_all ? 1'b0 :
                            lock_set[gi] ? 1'b1 :
                            (lock_q[gi] && edge_sense[gi] && dreq_act[gi]);
        assign grant_onehot_d[gi] = grant_valid_d && (grant_channel_d == CH_W'(gi));
    end

    // Winner search: rotate candidates so the highest-priority channel sits at bit 0
    always_comb begin
        base    = cmd_rotating_q ? ptr_q : '0;
        act_dbl = {act, act} >> base;
        act_rot = act_dbl[CHANNELS-1:0];
        win_off = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (act_rot[i]) begin
                win_off = CH_W'(i);
            end
        end
        win_sum = {1'b0, base} + {1'b0, win_off};
        if (win_sum >= CH_COUNT) begin
            win_sum = win_sum - CH_COUNT;
        end
        winner = win_sum[CH_W-1:0];
    end

    // Next-state for the grant FSM and all programmable registers
    always_comb begin
        state_d          = state_q;
        grant_channel_d  = grant_channel_q;
        ptr_d            = ptr_q;
        mask_d           = mask_q;
        softreq_d        = softreq_q;
        cmd_disable_d    = cmd_disable_q;
        cmd_rotating_d   = cmd_rotating_q;
        cmd_active_low_d = cmd_active_low_q;

        case (state_q)
            ST_IDLE: begin
                if (act_any && !cmd_disable_q) begin
                    grant_channel_d = winner;
                    state_d         = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // Held offer: no re-arbitration, only accept or withdraw
                if (gnt.grant_accept) begin
                    state_d = ST_BUSY;
                end else if (!act[grant_channel_q] || cmd_disable_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (gnt.service_done) begin
                    state_d = ST_IDLE;
                    if (cmd_rotating_q) begin
                        ptr_d = ptr_after_grant;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (write_command) begin
            cmd_disable_d    = cmd_disable;
            cmd_rotating_d   = cmd_rotating;
            cmd_active_low_d = cmd_active_low;
            ptr_d            = '0;
        end

        if (mask_set_all) begin
            mask_d = '1;
        end else if (mask_single) begin
            mask_d[mask_channel] = mask_value;
        end else if (mask_write_all) begin
            mask_d = mask_bus;
        end

        // EOP clears the software request; a same-cycle request_write overrides it
        if (in_busy && gnt.end_of_process) begin
            softreq_d[grant_channel_q] = 1'b0;
        end
        if (request_write) begin
            softreq_d[request_channel] = request_value;
        end
        if (mask_set_all) begin
            softreq_d = '0;
        end

        grant_valid_d = (state_d != ST_IDLE);
    end

    // State registers with synchronous reset / master clear
    always_ff @(posedge clock) begin
        if (!reset_n || master_clear) begin
            state_q          <= ST_IDLE;
            mask_q           <= '1;
            softreq_q        <= '0;
            lock_q           <= '0;
            ptr_q            <= '0;
            cmd_disable_q    <= 1'b0;
            cmd_rotating_q   <= 1'b0;
            cmd_active_low_q <= 1'b0;
            grant_channel_q  <= '0;
            grant_valid_q    <= 1'b0;
            grant_onehot_q   <= '0;
        end else begin
            state_q          <= state_d;
            mask_q           <= mask_d;
            softreq_q        <= softreq_d;
            lock_q           <= lock_d;
            ptr_q            <= ptr_d;
            cmd_disable_q    <= cmd_disable_d;
            cmd_rotating_q   <= cmd_rotating_d;
            cmd_active_low_q <= cmd_active_low_d;
            grant_channel_q  <= grant_channel_d;
            grant_valid_q    <= grant_valid_d;
            grant_onehot_q   <= grant_onehot_d;
        end
    end

    assign gnt.grant_valid   = grant_valid_q;
    assign gnt.grant_channel = grant_channel_q;
    assign gnt.grant_onehot  = grant_onehot_q;

endmodule

// File: tb/tb_kf_dma_priority_arbiter.sv
// Directed bench for kf_dma_priority_arbiter (8 channels): fixed and rotating
// priority, edge lock, software request, offer withdraw, disable and resets.
module tb_kf_dma_priority_arbiter;

    localparam int CHANNELS = 8;
    localparam int CH_W     = $clog2(CHANNELS);

    logic                clock = 1'b0;
    logic                reset_n;
    logic                master_clear;
    logic                write_command;
    logic                cmd_disable;
    logic                cmd_rotating;
    logic                cmd_active_low;
    logic                mask_set_all;
    logic                mask_single;
    logic [CH_W-1:0]     mask_channel;
    logic                mask_value;
    logic                mask_write_all;
    logic [CHANNELS-1:0] mask_bus;
    logic                request_write;
    logic [CH_W-1:0]     request_channel;
    logic                request_value;
    logic [CHANNELS-1:0] edge_sense;
    logic [CHANNELS-1:0] dma_request;

    int total;
    int bad;

    kf_dma_priority_arbiter_if #(.CHANNELS(CHANNELS)) u_if ();

    kf_dma_priority_arbiter #(.CHANNELS(CHANNELS)) u_dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .master_clear    (master_clear),
        .write_command   (write_command),
        .cmd_disable     (cmd_disable),
        .cmd_rotating    (cmd_rotating),
        .cmd_active_low  (cmd_active_low),
        .mask_set_all    (mask_set_all),
        .mask_single     (mask_single),
        .mask_channel    (mask_channel),
        .mask_value      (mask_value),
        .mask_write_all  (mask_write_all),
        .mask_bus        (mask_bus),
        .request_write   (request_write),
        .request_channel (request_channel),
        .request_value   (request_value),
        .edge_sense      (edge_sense),
        .dma_request     (dma_request),
        .gnt             (u_if)
    );

    always #5 clock = ~clock;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // Accept the current offer, then finish service
    task automatic serve();
        u_if.grant_accept = 1'b1;
        tick();
        u_if.grant_accept = 1'b0;
        u_if.service_done = 1'b1;
        tick();
        u_if.service_done = 1'b0;
    endtask

    task automatic write_cmd(input logic dis, input logic rot, input logic al);
        write_command  = 1'b1;
        cmd_disable    = dis;
        cmd_rotating   = rot;
        cmd_active_low = al;
        tick();
        write_command  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0; master_clear = 1'b0;
        write_command = 1'b0; cmd_disable = 1'b0; cmd_rotating = 1'b0; cmd_active_low = 1'b0;
        mask_set_all = 1'b0; mask_single = 1'b0; mask_channel = '0; mask_value = 1'b0;
        mask_write_all = 1'b0; mask_bus = '0;
        request_write = 1'b0; request_channel = '0; request_value = 1'b0;
        edge_sense = '0; dma_request = '0;
        u_if.grant_accept = 1'b0; u_if.service_done = 1'b0; u_if.end_of_process = 1'b0;

        // Reset state
        tick(); tick();
        reset_n = 1'b1;
        check("rst_valid",  32'(u_if.grant_valid),   32'd0);
        check("rst_chan",   32'(u_if.grant_channel), 32'd0);
        check("rst_onehot", 32'(u_if.grant_onehot),  32'd0);
        dma_request = 8'hFF;
        tick(); tick();
        check("rst_mask_blocks", 32'(u_if.grant_valid), 32'd0);
        dma_request = 8'h00;
        mask_write_all = 1'b1; mask_bus = 8'h00;
        tick();
        mask_write_all = 1'b0;

        // Fixed priority, level sense
        dma_request = 8'b0000_1010;
        tick();
        check("t1_valid",  32'(u_if.grant_valid),   32'd1);
        check("t1_chan",   32'(u_if.grant_channel), 32'd1);
        check("t1_onehot", 32'(u_if.grant_onehot),  32'h02);
        u_if.grant_accept = 1'b1;
        tick();
        u_if.grant_accept = 1'b0;
        check("t1_busy_valid", 32'(u_if.grant_valid),   32'd1);
        check("t1_busy_chan",  32'(u_if.grant_channel), 32'd1);
        u_if.service_done = 1'b1;
        tick();
        u_if.service_done = 1'b0;
        check("t1_gap_valid", 32'(u_if.grant_valid), 32'd0);
        tick();
        check("t1_regrant_valid", 32'(u_if.grant_valid),   32'd1);
        check("t1_regrant_chan",  32'(u_if.grant_channel), 32'd1);
        dma_request = 8'b0000_1000;
        tick();
        check("t1_withdraw_valid", 32'(u_if.grant_valid), 32'd0);
        tick();
        check("t1_ch3_chan",   32'(u_if.grant_channel), 32'd3);
        check("t1_ch3_onehot", 32'(u_if.grant_onehot),  32'h08);
        serve();
        dma_request = 8'h00;
        tick();
        check("t1_idle_valid", 32'(u_if.grant_valid), 32'd0);

        // Rotating priority over all eight channels
        write_cmd(1'b0, 1'b1, 1'b0);
        dma_request = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("t2_rot_chan", 32'(u_if.grant_channel), 32'(k % 8));
            serve();
        end
        dma_request = 8'h00;
        write_cmd(1'b0, 1'b1, 1'b0);
        dma_request = 8'hFF;
        tick();
        check("t2_ptr_reset_chan", 32'(u_if.grant_channel), 32'd0);
        serve();
        dma_request = 8'h00;
        write_cmd(1'b0, 1'b0, 1'b0);

        // Edge-sensed channel 2
        edge_sense  = 8'h04;
        dma_request = 8'h04;
        tick();
        check("t3_first_valid", 32'(u_if.grant_valid),   32'd1);
        check("t3_first_chan",  32'(u_if.grant_channel), 32'd2);
        serve();
        tick();
        check("t3_locked_a", 32'(u_if.grant_valid), 32'd0);
        tick();
        check("t3_locked_b", 32'(u_if.grant_valid), 32'd0);
        dma_request = 8'h00;
        tick();
        dma_request = 8'h04;
        tick();
        check("t3_rearm_valid", 32'(u_if.grant_valid),   32'd1);
        check("t3_rearm_chan",  32'(u_if.grant_channel), 32'd2);
        serve();
        dma_request = 8'h00;
        edge_sense  = 8'h00;
        tick();

        // Software request on masked channel 5, cleared by EOP
        mask_single = 1'b1; mask_channel = 3'd5; mask_value = 1'b1;
        request_write = 1'b1; request_channel = 3'd5; request_value = 1'b1;
        tick();
        mask_single = 1'b0; request_write = 1'b0;
        dma_request = 8'h20;
        tick();
        check("t4_soft_valid", 32'(u_if.grant_valid),   32'd1);
        check("t4_soft_chan",  32'(u_if.grant_channel), 32'd5);
        u_if.grant_accept = 1'b1;
        tick();
        u_if.grant_accept = 1'b0;
        u_if.end_of_process = 1'b1;
        tick();
        u_if.end_of_process = 1'b0;
        u_if.service_done = 1'b1;
        tick();
        u_if.service_done = 1'b0;
        tick();
        check("t4_no_regrant_a", 32'(u_if.grant_valid), 32'd0);
        tick();
        check("t4_no_regrant_b", 32'(u_if.grant_valid), 32'd0);
        dma_request = 8'h00;

        // Offer withdraw, then disable while busy
        dma_request = 8'h01;
        tick();
        check("t5_offer_valid", 32'(u_if.grant_valid),   32'd1);
        check("t5_offer_chan",  32'(u_if.grant_channel), 32'd0);
        dma_request = 8'h00;
        tick();
        check("t5_withdraw_valid",  32'(u_if.grant_valid),  32'd0);
        check("t5_withdraw_onehot", 32'(u_if.grant_onehot), 32'd0);
        dma_request = 8'h01;
        tick();
        check("t5_regrant_valid", 32'(u_if.grant_valid), 32'd1);
        u_if.grant_accept = 1'b1;
        tick();
        u_if.grant_accept = 1'b0;
        dma_request = 8'h00;
        write_cmd(1'b1, 1'b0, 1'b0);
        check("t5_busy_hold_valid", 32'(u_if.grant_valid), 32'd1);
        tick();
        check("t5_busy_hold_valid2", 32'(u_if.grant_valid),   32'd1);
        check("t5_busy_hold_chan",   32'(u_if.grant_channel), 32'd0);
        dma_request = 8'h01;
        u_if.service_done = 1'b1;
        tick();
        u_if.service_done = 1'b0;
        check("t5_done_valid", 32'(u_if.grant_valid), 32'd0);
        tick();
        check("t5_disabled_a", 32'(u_if.grant_valid), 32'd0);
        tick();
        check("t5_disabled_b", 32'(u_if.grant_valid), 32'd0);
        write_cmd(1'b0, 1'b0, 1'b0);
        check("t5_enable_edge_valid", 32'(u_if.grant_valid), 32'd0);
        tick();
        check("t5_reenabled_valid", 32'(u_if.grant_valid), 32'd1);
        u_if.grant_accept = 1'b1;
        tick();
        u_if.grant_accept = 1'b0;

        // reset_n while busy
        write_cmd(1'b0, 1'b1, 1'b1);
        check("t6_busy_before_rst", 32'(u_if.grant_valid), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t6_rst_valid",  32'(u_if.grant_valid),   32'd0);
        check("t6_rst_chan",   32'(u_if.grant_channel), 32'd0);
        check("t6_rst_onehot", 32'(u_if.grant_onehot),  32'd0);
        cmd_rotating = 1'b0; cmd_active_low = 1'b0;
        dma_request = 8'h00;
        mask_write_all = 1'b1; mask_bus = 8'h00;
        tick();
        mask_write_all = 1'b0;
        tick();
        check("t6_active_low_cleared", 32'(u_if.grant_valid), 32'd0);
        dma_request = 8'h0C;
        tick();
        check("t6_fixed_chan", 32'(u_if.grant_channel), 32'd2);
        u_if.grant_accept = 1'b1;
        tick();
        u_if.grant_accept = 1'b0;

        // master_clear while busy
        master_clear = 1'b1;
        tick();
        master_clear = 1'b0;
        check("t6_mc_valid",  32'(u_if.grant_valid),   32'd0);
        check("t6_mc_chan",   32'(u_if.grant_channel), 32'd0);
        check("t6_mc_onehot", 32'(u_if.grant_onehot),  32'd0);
        tick();
        check("t6_mc_mask_blocks", 32'(u_if.grant_valid), 32'd0);

        // Mask write precedence
        mask_single = 1'b1; mask_channel = 3'd3; mask_value = 1'b0;
        mask_write_all = 1'b1; mask_bus = 8'h00;
        tick();
        mask_single = 1'b0; mask_write_all = 1'b0;
        tick();
        check("t6_single_over_all_chan", 32'(u_if.grant_channel), 32'd3);
        mask_set_all = 1'b1; mask_single = 1'b1; mask_channel = 3'd2; mask_value = 1'b0;
        tick();
        mask_set_all = 1'b0; mask_single = 1'b0;
        check("t6_offer_kept_valid", 32'(u_if.grant_valid), 32'd1);
        tick();
        check("t6_setall_withdraw", 32'(u_if.grant_valid), 32'd0);
        tick();
        check("t6_setall_over_single", 32'(u_if.grant_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
